// File: rtl/tlp_pkg.sv
// Shared constants and types for the TLP transmit scheduler.
// Provides header fmt/type encodings, scheduler FSM states and source identifiers.
package tlp_pkg;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;

  typedef enum logic {IDLE, SEND} sched_state_e;
  typedef enum logic {SRC_MEM, SRC_CPL} src_e;

endpackage

// File: rtl/tlp_credit_counter.sv
// Saturating up/down counter for downstream request header credits.
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset (reloads CREDIT_MAX)
//   dec_i           consume one credit (caller guarantees cnt_o != 0)
//   inc_i           one credit returned; saturates at CREDIT_MAX
//   cnt_o           available credits (registered)
//   zero_c          cnt_o == 0, combinational from the register
module tlp_credit_counter #(
  parameter int unsigned CREDIT_MAX = 8,
  parameter int unsigned CW         = $clog2(CREDIT_MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_c
);

  assign zero_c = (cnt_o == '0);

  // Simultaneous consume and return cancel out.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_o <= CW'(CREDIT_MAX);
    end else begin
      case ({dec_i, inc_i})
        2'b10:   if (cnt_o != '0) cnt_o <= cnt_o - CW'(1);
        2'b01:   if (cnt_o != CW'(CREDIT_MAX)) cnt_o <= cnt_o + CW'(1);
        default: cnt_o <= cnt_o;
      endcase
    end
  end

endmodule

// File: rtl/tlp_tx_scheduler.sv
// Transmit-side TLP scheduler: arbitrates memory requests against completions,
// registers the winner's header and payload and holds them until accepted.
// Memory requests are gated by downstream header credits.
// Build option: TLP_TX_CPL_PRIO_EN -- completions win every tie (strict priority);
// otherwise ties are resolved round-robin.
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   cfg_dev_id_i              own requester/completer ID
//   mem_* / cpl_*             request and completion sources (valid/ready, fields, payload)
//   credit_ret_i              one request header credit returned
//   tlp_valid_o/tlp_ready_i   handshake toward the packetizer
//   hdr_*_o, addr_o, data_o   registered TLP fields
//   credit_cnt_o              available request credits
module tlp_tx_scheduler
  import tlp_pkg::*;
#(
  parameter int unsigned CREDIT_MAX = 8,
  parameter int unsigned DATA_W     = 512,
  localparam int unsigned CW        = $clog2(CREDIT_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [15:0]       cfg_dev_id_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic              mem_wr_i,
  input  logic [2:0]        mem_tc_i,
  input  logic [9:0]        mem_length_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              cpl_valid_i,
  output logic              cpl_ready_o,
  input  logic [2:0]        cpl_tc_i,
  input  logic [9:0]        cpl_length_i,
  input  logic [15:0]       cpl_req_id_i,
  input  logic [DATA_W-1:0] cpl_data_i,
  input  logic              credit_ret_i,
  output logic              tlp_valid_o,
  input  logic              tlp_ready_i,
  output logic [2:0]        hdr_fmt_o,
  output logic [4:0]        hdr_type_o,
  output logic [2:0]        hdr_tc_o,
  output logic [9:0]        hdr_length_o,
  output logic [15:0]       hdr_req_id_o,
  output logic [15:0]       hdr_cpl_id_o,
  output logic [31:0]       addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CW-1:0]     credit_cnt_o
);

  sched_state_e state, next_state;
  logic         credit_zero;
  logic         mem_elig;
  logic         cpl_elig;

  tlp_credit_counter #(
    .CREDIT_MAX (CREDIT_MAX),
    .CW         (CW)
  ) u_credit (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .dec_i   (mem_ready_o),
    .inc_i   (credit_ret_i),
    .cnt_o   (credit_cnt_o),
    .zero_c  (credit_zero)
  );

  assign mem_elig = mem_valid_i && !credit_zero;
  assign cpl_elig = cpl_valid_i;

`ifndef TLP_TX_CPL_PRIO_EN
  src_e last_grant;

  // Remember the last winner so the other source takes the next tie.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_grant <= SRC_CPL;
    end else if (mem_ready_o) begin
      last_grant <= SRC_MEM;
    end else if (cpl_ready_o) begin
      last_grant <= SRC_CPL;
    end
  end
`endif

  // Next-state and one-hot grant logic.
  always_comb begin
    next_state  = state;
    mem_ready_o = 1'b0;
    cpl_ready_o = 1'b0;
    case (state)
      IDLE: begin
        if (mem_elig && cpl_elig) begin
`ifdef TLP_TX_CPL_PRIO_EN
          cpl_ready_o = 1'b1;
`else
          mem_ready_o = (last_grant == SRC_CPL);
          cpl_ready_o = (last_grant == SRC_MEM);
`endif
        end else begin
          mem_ready_o = mem_elig;
          cpl_ready_o = cpl_elig;
        end
        if (mem_ready_o || cpl_ready_o) next_state = SEND;
      end
      SEND: begin
        if (tlp_ready_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and output capture; fields only change on a grant.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      tlp_valid_o  <= 1'b0;
      hdr_fmt_o    <= '0;
      hdr_type_o   <= '0;
      hdr_tc_o     <= '0;
      hdr_length_o <= '0;
      hdr_req_id_o <= '0;
      hdr_cpl_id_o <= '0;
      addr_o       <= '0;
      data_o       <= '0;
    end else begin
      state       <= next_state;
      tlp_valid_o <= (next_state == SEND);
      if (mem_ready_o) begin
        hdr_fmt_o    <= mem_wr_i ? FMT_3DW_DATA : FMT_3DW_NODATA;
        hdr_type_o   <= TYPE_MEM;
        hdr_tc_o     <= mem_tc_i;
        hdr_length_o <= mem_length_i;
        hdr_req_id_o <= cfg_dev_id_i;
        hdr_cpl_id_o <= '0;
        addr_o       <= mem_addr_i & 32'hFFFF_FFFC;
        data_o       <= mem_wr_i ? mem_data_i : '0;
      end else if (cpl_ready_o) begin
        hdr_fmt_o    <= (cpl_length_i != '0) ? FMT_3DW_DATA : FMT_3DW_NODATA;
        hdr_type_o   <= TYPE_CPL;
        hdr_tc_o     <= cpl_tc_i;
        hdr_length_o <= cpl_length_i;
        hdr_req_id_o <= cpl_req_id_i;
        hdr_cpl_id_o <= cfg_dev_id_i;
        addr_o       <= '0;
        data_o       <= (cpl_length_i != '0) ? cpl_data_i : '0;
      end
    end
  end

endmodule
